// File: rtl/cnn_sched_pkg.sv
// Shared types for the CNN tile scheduler: FSM states, padding flag bit
// positions and the layer descriptor held for the duration of a layer.
package cnn_sched_pkg;

    localparam int PAD_L = 0;
    localparam int PAD_R = 1;
    localparam int PAD_T = 2;
    localparam int PAD_B = 3;

    // Descriptor field widths; these track the scheduler's default parameters.
    localparam int DESC_IMG_H_W = 10;
    localparam int DESC_IMG_W_W = 6;
    localparam int DESC_CH_W    = 8;
    localparam int DESC_K_W     = 3;
    localparam int DESC_S_W     = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_ISSUE,
        ST_RUN,
        ST_FIN,
        ST_NEXT
    } sched_state_e;

    typedef struct packed {
        logic [DESC_IMG_H_W-1:0] img_h;
        logic [DESC_IMG_W_W-1:0] img_w;
        logic [DESC_CH_W-1:0]    channels;
        logic [DESC_K_W-1:0]     kernel_w;
        logic [DESC_K_W-1:0]     kernel_h;
        logic [DESC_S_W-1:0]     stride;
        logic [DESC_K_W-1:0]     padding;
        logic [1:0]              buf_size;
    } sched_desc_t;

endpackage

// File: rtl/cnn_step_calc.sv
// Sequential subtract divider: out_rows = floor((BUFFER_DEPTH - kernel_h) / stride) + 1
// and step = out_rows * stride. done is high in the last busy cycle.
module cnn_step_calc #(
    parameter int BUFFER_DEPTH = 8,
    parameter int KERNEL_WIDTH = 3,
    parameter int STRIDE_WIDTH = 2,
    parameter int ROWS_W       = $clog2(BUFFER_DEPTH) + 1,
    parameter int STEP_W       = ROWS_W + STRIDE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [KERNEL_WIDTH-1:0] kernel_h,
    input  logic [STRIDE_WIDTH-1:0] stride,
    output logic                    done,
    output logic [ROWS_W-1:0]       out_rows,
    output logic [STEP_W-1:0]       step
);

    localparam logic [ROWS_W-1:0] DEPTH_C = ROWS_W'(BUFFER_DEPTH);

    logic              busy;
    logic [ROWS_W-1:0] rem;
    logic [ROWS_W-1:0] stride_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy     <= 1'b0;
            rem      <= '0;
            stride_q <= '0;
            out_rows <= '0;
            step     <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            rem      <= DEPTH_C - ROWS_W'(kernel_h);
            stride_q <= ROWS_W'(stride);
            out_rows <= ROWS_W'(1);
            step     <= STEP_W'(stride);
        end else if (busy) begin
            if (rem >= stride_q) begin
                rem      <= rem - stride_q;
                out_rows <= out_rows + ROWS_W'(1);
                step     <= step + STEP_W'(stride_q);
            end else begin
                busy <= 1'b0;
            end
        end
    end

    assign done = busy && (rem < stride_q);

endmodule

// File: rtl/cnn_tile_scheduler.sv
// Splits a convolution layer into row tiles and channels, driving the line
// buffer configuration and start/finish handshakes, and counting windows.
module cnn_tile_scheduler
    import cnn_sched_pkg::*;
#(
    parameter int BUFFER_DEPTH = 8,
    parameter int BUFFER_WIDTH = 32,
    parameter int KERNEL_WIDTH = 3,
    parameter int STRIDE_WIDTH = 2,
    parameter int IMG_H_WIDTH  = 10,
    parameter int CH_WIDTH     = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              desc_valid,
    output logic                              desc_ready,
    input  logic [IMG_H_WIDTH-1:0]            desc_img_h,
    input  logic [$clog2(BUFFER_WIDTH):0]     desc_img_w,
    input  logic [CH_WIDTH-1:0]               desc_channels,
    input  logic [KERNEL_WIDTH-1:0]           desc_kernel_w,
    input  logic [KERNEL_WIDTH-1:0]           desc_kernel_h,
    input  logic [STRIDE_WIDTH-1:0]           desc_stride,
    input  logic [KERNEL_WIDTH-1:0]           desc_padding,
    input  logic [1:0]                        desc_buf_size,
    output logic [KERNEL_WIDTH-1:0]           kernel_width_o,
    output logic [KERNEL_WIDTH-1:0]           kernel_height_o,
    output logic [STRIDE_WIDTH-1:0]           stride_o,
    output logic [KERNEL_WIDTH-1:0]           padding_o,
    output logic [$clog2(BUFFER_DEPTH)-1:0]   buffer_depth_o,
    output logic [$clog2(BUFFER_WIDTH)-1:0]   buffer_width_o,
    output logic [3:0]                        padding_valid_o,
    output logic [1:0]                        buf_size_o,
    output logic                              buf_refresh_o,
    output logic                              req_o,
    output logic                              req_final_o,
    input  logic                              window_valid_i,
    input  logic                              window_finish_i,
    output logic [IMG_H_WIDTH-1:0]            tile_row_base_o,
    output logic [CH_WIDTH-1:0]               tile_ch_o,
    output logic [31:0]                       window_cnt_o,
    output logic                              busy_o,
    output logic                              layer_done_o,
    output logic                              err_o
);

    localparam int DEPTH_W = $clog2(BUFFER_DEPTH);
    localparam int WIDTH_W = $clog2(BUFFER_WIDTH);
    localparam int ROWS_W  = DEPTH_W + 1;
    localparam int STEP_W  = ROWS_W + STRIDE_WIDTH;

    localparam logic [WIDTH_W:0]      MAX_IMG_W = (WIDTH_W + 1)'(BUFFER_WIDTH);
    localparam logic [KERNEL_WIDTH:0] MAX_K_H   = (KERNEL_WIDTH + 1)'(BUFFER_DEPTH);

    sched_state_e          state_q, state_d;
    sched_desc_t           desc_q;
    logic [IMG_H_WIDTH-1:0] row_base_q, nxt_row_base;
    logic [CH_WIDTH-1:0]   ch_q, nxt_ch;
    logic                  handshake, desc_bad;
    logic                  calc_start, calc_done;
    logic                  load_tile, layer_end;
    logic [ROWS_W-1:0]     calc_rows_unused;
    logic [STEP_W-1:0]     step;

    function automatic logic is_last(input logic [IMG_H_WIDTH-1:0] img_h,
                                     input logic [IMG_H_WIDTH-1:0] rb);
        return ({1'b0, rb} + (IMG_H_WIDTH + 1)'(BUFFER_DEPTH)) >= {1'b0, img_h};
    endfunction

    // Tile height minus one; the buffer never holds more than BUFFER_DEPTH rows.
    function automatic logic [DEPTH_W-1:0] rows_m1(input logic [IMG_H_WIDTH-1:0] img_h,
                                                   input logic [IMG_H_WIDTH-1:0] rb);
        logic [IMG_H_WIDTH-1:0] diff;
        diff = img_h - rb;
        if (diff >= IMG_H_WIDTH'(BUFFER_DEPTH)) return '1;
        return DEPTH_W'(diff) - DEPTH_W'(1);
    endfunction

    function automatic logic [3:0] pad_flags(input sched_desc_t d,
                                             input logic [IMG_H_WIDTH-1:0] rb);
        logic       pad_nz;
        logic [3:0] f;
        pad_nz   = (d.padding != '0);
        f        = '0;
        f[PAD_L] = pad_nz;
        f[PAD_R] = pad_nz;
        f[PAD_T] = pad_nz && (rb == '0);
        f[PAD_B] = pad_nz && is_last(d.img_h, rb);
        return f;
    endfunction

    assign handshake = desc_valid && (state_q == ST_IDLE);
    assign desc_bad  = (desc_img_w > MAX_IMG_W) || ({1'b0, desc_kernel_h} > MAX_K_H) ||
                       (desc_img_h == '0) || (desc_img_w == '0) || (desc_channels == '0) ||
                       (desc_kernel_w == '0) || (desc_kernel_h == '0) || (desc_stride == '0);

    cnn_step_calc #(
        .BUFFER_DEPTH (BUFFER_DEPTH),
        .KERNEL_WIDTH (KERNEL_WIDTH),
        .STRIDE_WIDTH (STRIDE_WIDTH)
    ) u_step_calc (
        .clk      (clk),
        .rst      (rst),
        .start    (calc_start),
        .kernel_h (desc_kernel_h),
        .stride   (desc_stride),
        .done     (calc_done),
        .out_rows (calc_rows_unused),
        .step     (step)
    );

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        calc_start    = 1'b0;
        load_tile     = 1'b0;
        layer_end     = 1'b0;
        nxt_row_base  = row_base_q;
        nxt_ch        = ch_q;
        desc_ready    = 1'b0;
        req_o         = 1'b0;
        buf_refresh_o = 1'b0;
        req_final_o   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                desc_ready = 1'b1;
                if (desc_valid && !desc_bad) begin
                    calc_start = 1'b1;
                    state_d    = ST_CALC;
                end
            end
            ST_CALC: begin
                if (calc_done) begin
                    load_tile    = 1'b1;
                    nxt_row_base = '0;
                    nxt_ch       = '0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                req_o         = 1'b1;
                buf_refresh_o = 1'b1;
                state_d       = ST_RUN;
            end
            ST_RUN: begin
                if (window_finish_i) state_d = ST_FIN;
            end
            ST_FIN: begin
                req_final_o = 1'b1;
                state_d     = ST_NEXT;
            end
            ST_NEXT: begin
                if (ch_q < desc_q.channels - CH_WIDTH'(1)) begin
                    nxt_ch    = ch_q + CH_WIDTH'(1);
                    load_tile = 1'b1;
                    state_d   = ST_ISSUE;
                end else if (!is_last(desc_q.img_h, row_base_q)) begin
                    // The first tile starts inside the top padding, so it advances less.
                    nxt_ch       = '0;
                    nxt_row_base = row_base_q + ((row_base_q == '0)
                                   ? IMG_H_WIDTH'(step) - IMG_H_WIDTH'(desc_q.padding)
                                   : IMG_H_WIDTH'(step));
                    load_tile    = 1'b1;
                    state_d      = ST_ISSUE;
                end else begin
                    layer_end = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            desc_q          <= '0;
            row_base_q      <= '0;
            ch_q            <= '0;
            kernel_width_o  <= '0;
            kernel_height_o <= '0;
            stride_o        <= '0;
            padding_o       <= '0;
            buffer_depth_o  <= '0;
            buffer_width_o  <= '0;
            padding_valid_o <= '0;
            buf_size_o      <= '0;
            window_cnt_o    <= '0;
            busy_o          <= 1'b0;
            layer_done_o    <= 1'b0;
            err_o           <= 1'b0;
        end else begin
            layer_done_o <= layer_end || (handshake && desc_bad);
            if (handshake) begin
                desc_q <= '{img_h: desc_img_h, img_w: desc_img_w, channels: desc_channels,
                            kernel_w: desc_kernel_w, kernel_h: desc_kernel_h,
                            stride: desc_stride, padding: desc_padding,
                            buf_size: desc_buf_size};
                window_cnt_o <= '0;
                err_o        <= desc_bad;
                busy_o       <= !desc_bad;
            end
            if (layer_end) busy_o <= 1'b0;
            if (state_q == ST_RUN && window_valid_i && window_cnt_o != '1)
                window_cnt_o <= window_cnt_o + 32'd1;
            if (load_tile) begin
                row_base_q      <= nxt_row_base;
                ch_q            <= nxt_ch;
                kernel_width_o  <= desc_q.kernel_w;
                kernel_height_o <= desc_q.kernel_h;
                stride_o        <= desc_q.stride;
                padding_o       <= desc_q.padding;
                buf_size_o      <= desc_q.buf_size;
                buffer_width_o  <= WIDTH_W'(desc_q.img_w - (WIDTH_W + 1)'(1));
                buffer_depth_o  <= rows_m1(desc_q.img_h, nxt_row_base);
                padding_valid_o <= pad_flags(desc_q, nxt_row_base);
            end
        end
    end

    assign tile_row_base_o = row_base_q;
    assign tile_ch_o       = ch_q;

endmodule
